// File: rtl/sys_defs.sv
// sys_defs: shared functional-unit encodings, FU FSM states and CDB scheduling defaults.
`ifndef SYS_FU_ADDR_WIDTH
`define SYS_FU_ADDR_WIDTH 3
`endif
package sys_defs;
    localparam int SYS_NUM_FU    = 2**`SYS_FU_ADDR_WIDTH;
    localparam int SYS_CDB_WIDTH = 3;
    localparam int SYS_MULT_LAT  = 4;
    typedef enum logic [2:0] {ALU_1, ALU_2, ALU_3, LS_1, LS_2, MULT_1, MULT_2, BRANCH} FU_SELECT;
    typedef logic [SYS_NUM_FU-1:0] FU_STATE_PACKET;
    typedef enum logic [1:0] {FU_IDLE, FU_BUSY, FU_WAIT_CDB} FU_FSM_STATE;
endpackage

// File: rtl/rr_multi_grant.sv
// rr_multi_grant: combinational round-robin selector granting up to W requesters,
// scanning upward from ptr with wrap-around.
module rr_multi_grant #(
    parameter int N  = 8,
    parameter int W  = 3,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);
    logic [PW-1:0] idx;
    int            cnt;
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        idx      = ptr;
        cnt      = 0;
        for (int k = 0; k < N; k++) begin
            if (req[idx] && cnt < W) begin
                grant[idx] = 1'b1;
                cnt        = cnt + 1;
                next_ptr   = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/fu_cdb_scheduler.sv
// fu_cdb_scheduler: per-FU IDLE/BUSY/WAIT_CDB tracking and round-robin CDB writeback grants.
module fu_cdb_scheduler
    import sys_defs::*;
#(
    parameter int NUM_FU    = 2**`SYS_FU_ADDR_WIDTH,
    parameter int CDB_WIDTH = SYS_CDB_WIDTH,
    parameter int MULT_LAT  = SYS_MULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_FU-1:0] fu_issue_valid,
    input  logic [1:0]        ls_done,
    input  logic              squash,
    output logic [NUM_FU-1:0] fu_ready_is,
    output logic [NUM_FU-1:0] cdb_grant,
    output logic [NUM_FU-1:0] cdb_req
);
    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT - 1);

    logic [NUM_FU-1:0] raw_grant;
    logic [PW-1:0]     rr_ptr, next_ptr;

    rr_multi_grant #(.N(NUM_FU), .W(CDB_WIDTH), .PW(PW)) u_rr (
        .req(cdb_req), .ptr(rr_ptr), .grant(raw_grant), .next_ptr(next_ptr)
    );

    assign cdb_grant = squash ? '0 : raw_grant;

    always_ff @(posedge clk or negedge rst)
        if (!rst) rr_ptr <= '0;
        else if (!squash && |raw_grant) rr_ptr <= next_ptr;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        localparam bit IS_LS   = (i == int'(LS_1)) || (i == int'(LS_2));
        localparam bit IS_MULT = (i == int'(MULT_1)) || (i == int'(MULT_2));
        localparam int LSJ     = IS_LS ? i - int'(LS_1) : 0;
        FU_FSM_STATE state;
        logic [3:0]  cnt;
        logic        issue;
        assign cdb_req[i]     = state == FU_WAIT_CDB;
        assign fu_ready_is[i] = (state == FU_IDLE) || cdb_grant[i];
        assign issue          = fu_issue_valid[i] && fu_ready_is[i];
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                state <= FU_IDLE;
                cnt   <= '0;
            end else if (squash) begin
                state <= FU_IDLE;
                cnt   <= '0;
            end else if (issue) begin
                state <= FU_BUSY;
                cnt   <= IS_MULT ? MULT_LOAD : '0;
            end else if (state == FU_BUSY) begin
                if (IS_MULT) begin
                    if (cnt == '0) state <= FU_WAIT_CDB;
                    else cnt <= cnt - 4'd1;
                end else if (!IS_LS || ls_done[LSJ]) state <= FU_WAIT_CDB;
            end else if (cdb_grant[i]) state <= FU_IDLE;
`ifndef SYNTHESIS
        // an issue to an FU that is not ready is dropped; flag it in simulation
        assert property (@(posedge clk) disable iff (!rst) fu_issue_valid[i] && !squash |-> fu_ready_is[i])
            else $error("issue to busy fu %0d ignored", i);
`endif
    end
endmodule

// File: tb/tb_fu_cdb_scheduler.sv
// tb_fu_cdb_scheduler: directed table vectors plus hand sequences for multi-grant, squash and async reset.
module tb_fu_cdb_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] fu_issue_valid = '0;
    logic [1:0] ls_done = '0;
    logic       squash = 1'b0;
    logic [7:0] fu_ready_is, cdb_grant, cdb_req;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fu_cdb_scheduler #(.NUM_FU(8), .CDB_WIDTH(3), .MULT_LAT(4)) dut (
        .clk(clk), .rst(rst), .fu_issue_valid(fu_issue_valid), .ls_done(ls_done),
        .squash(squash), .fu_ready_is(fu_ready_is), .cdb_grant(cdb_grant), .cdb_req(cdb_req)
    );

    typedef struct {
        logic [7:0] issue;
        logic [1:0] ls;
        logic       sq;
        logic [7:0] ready;
        logic [7:0] grant;
        logic [7:0] req;
    } vec_t;

    vec_t tbl [22];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [7:0] r, input logic [7:0] g, input logic [7:0] q);
        check({tag, " ready"}, fu_ready_is, r);
        check({tag, " grant"}, cdb_grant, g);
        check({tag, " req"}, cdb_req, q);
    endtask

    task automatic drive(input logic [7:0] iss, input logic [1:0] ls, input logic sq);
        @(negedge clk);
        fu_issue_valid = iss;
        ls_done = ls;
        squash = sq;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        fu_issue_valid = '0;
        ls_done = '0;
        squash = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{8'h01, 2'b00, 1'b0, 8'hFF, 8'h00, 8'h00};
        tbl[1]  = '{8'h00, 2'b00, 1'b0, 8'hFE, 8'h00, 8'h00};
        tbl[2]  = '{8'h01, 2'b00, 1'b0, 8'hFF, 8'h01, 8'h01};
        tbl[3]  = '{8'h20, 2'b00, 1'b0, 8'hFE, 8'h00, 8'h00};
        tbl[4]  = '{8'h00, 2'b00, 1'b0, 8'hDF, 8'h01, 8'h01};
        tbl[5]  = '{8'h00, 2'b00, 1'b0, 8'hDF, 8'h00, 8'h00};
        tbl[6]  = '{8'h00, 2'b00, 1'b0, 8'hDF, 8'h00, 8'h00};
        tbl[7]  = '{8'h00, 2'b00, 1'b0, 8'hDF, 8'h00, 8'h00};
        tbl[8]  = '{8'h00, 2'b00, 1'b0, 8'hFF, 8'h20, 8'h20};
        tbl[9]  = '{8'h08, 2'b01, 1'b0, 8'hFF, 8'h00, 8'h00};
        tbl[10] = '{8'h00, 2'b00, 1'b0, 8'hF7, 8'h00, 8'h00};
        tbl[11] = '{8'h00, 2'b01, 1'b0, 8'hF7, 8'h00, 8'h00};
        tbl[12] = '{8'h00, 2'b01, 1'b0, 8'hFF, 8'h08, 8'h08};
        tbl[13] = '{8'h97, 2'b00, 1'b0, 8'hFF, 8'h00, 8'h00};
        tbl[14] = '{8'h00, 2'b10, 1'b0, 8'h68, 8'h00, 8'h00};
        tbl[15] = '{8'h20, 2'b00, 1'b1, 8'h68, 8'h00, 8'h97};
        tbl[16] = '{8'h00, 2'b00, 1'b0, 8'hFF, 8'h00, 8'h00};
        tbl[17] = '{8'h87, 2'b00, 1'b0, 8'hFF, 8'h00, 8'h00};
        tbl[18] = '{8'h00, 2'b00, 1'b0, 8'h78, 8'h00, 8'h00};
        tbl[19] = '{8'h00, 2'b00, 1'b0, 8'hFB, 8'h83, 8'h87};
        tbl[20] = '{8'h00, 2'b00, 1'b0, 8'hFF, 8'h04, 8'h04};
        tbl[21] = '{8'h00, 2'b00, 1'b0, 8'hFF, 8'h00, 8'h00};

        // idle while held in reset and for ten cycles after release
        repeat (2) @(negedge clk);
        #1;
        check3("in_reset", 8'hFF, 8'h00, 8'h00);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(8'h00, 2'b00, 1'b0);
            check3($sformatf("idle c%0d", c), 8'hFF, 8'h00, 8'h00);
        end

        for (int v = 0; v < 22; v++) begin
            drive(tbl[v].issue, tbl[v].ls, tbl[v].sq);
            check3($sformatf("vec%0d", v), tbl[v].ready, tbl[v].grant, tbl[v].req);
        end

        // all eight FUs reach WAIT_CDB together: grants 3,3,2 then pointer wraps to 0
        do_reset();
        drive(8'h60, 2'b11, 1'b0);
        check("all t0 ready", fu_ready_is, 8'hFF);
        drive(8'h00, 2'b11, 1'b0);
        drive(8'h00, 2'b11, 1'b0);
        drive(8'h9F, 2'b11, 1'b0);
        check3("all t3", 8'h9F, 8'h00, 8'h00);
        drive(8'h00, 2'b11, 1'b0);
        check3("all t4", 8'h00, 8'h00, 8'h00);
        drive(8'h00, 2'b11, 1'b0);
        check3("all t5", 8'h07, 8'h07, 8'hFF);
        drive(8'h00, 2'b11, 1'b0);
        check3("all t6", 8'h3F, 8'h38, 8'hF8);
        drive(8'h00, 2'b11, 1'b0);
        check3("all t7", 8'hFF, 8'hC0, 8'hC0);
        drive(8'h8F, 2'b11, 1'b0);
        check3("wrap t8", 8'hFF, 8'h00, 8'h00);
        drive(8'h00, 2'b11, 1'b0);
        check3("wrap t9", 8'h70, 8'h00, 8'h00);
        drive(8'h00, 2'b11, 1'b0);
        check3("wrap t10", 8'h77, 8'h07, 8'h8F);
        drive(8'h00, 2'b00, 1'b0);
        check3("wrap t11", 8'hFF, 8'h88, 8'h88);
        drive(8'h00, 2'b00, 1'b0);
        check3("wrap t12", 8'hFF, 8'h00, 8'h00);

        // asynchronous reset between edges while MULT_2 is busy
        drive(8'h40, 2'b00, 1'b0);
        drive(8'h00, 2'b00, 1'b0);
        check("mult2 busy ready", fu_ready_is, 8'hBF);
        #2;
        rst = 1'b0;
        #1;
        check3("async rst", 8'hFF, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive(8'h00, 2'b00, 1'b0);
            check3($sformatf("post rst c%0d", c), 8'hFF, 8'h00, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fu_cdb_scheduler.md
FU_CDB_SCHEDULER -- requirements
Module: fu_cdb_scheduler

Interface
REQ-001 SHALL have parameter NUM_FU, default 2**`SYS_FU_ADDR_WIDTH (8); FU index per FU_SELECT encoding (ALU_1..3, LS_1..2, MULT_1..2, BRANCH).
REQ-002 SHALL have parameter CDB_WIDTH, default 3; number of common-data-bus writeback ports per cycle.
REQ-003 SHALL have parameter MULT_LAT, default 4; multiplier execute cycles, legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 fu_issue_valid  input  NUM_FU  bit i = issued packet to FU i valid this cycle (from issue_stage iss_issued_fu_pkts[i].valid).
REQ-007 ls_done  input  2  bit j = load/store unit LS_1+j has result available.
REQ-008 squash  input  1  mispredict flush; discards all in-flight FU work.
REQ-009 fu_ready_is  output  FU_STATE_PACKET  per-FU ready bits driving issue_stage FIFO read-enable masks.
REQ-010 cdb_grant  output  NUM_FU  one-hot-per-FU writeback grant this cycle; at most CDB_WIDTH bits set.
REQ-011 cdb_req  output  NUM_FU  FUs currently in WAIT_CDB (debug/verification visibility).

Function
REQ-012 Each FU SHALL own a 3-state FSM: IDLE, BUSY, WAIT_CDB.
REQ-013 IDLE -> BUSY when fu_issue_valid[i]=1; issue while not ready SHALL be ignored and flagged by a simulation-only assertion.
REQ-014 ALU and BRANCH SHALL leave BUSY after exactly 1 cycle to WAIT_CDB.
REQ-015 MULT SHALL stay BUSY MULT_LAT cycles via a 4-bit per-FU down-counter loaded with MULT_LAT-1 on issue, then enter WAIT_CDB.
REQ-016 LS SHALL stay BUSY until ls_done[j]=1 (sampled in BUSY only), then enter WAIT_CDB next cycle.
REQ-017 WAIT_CDB -> IDLE on cycle cdb_grant[i]=1.
REQ-018 Arbitration SHALL grant up to CDB_WIDTH of the WAIT_CDB requesters per cycle, round-robin starting from rr_ptr, scanning ascending index with wrap-around at NUM_FU-1 -> 0.
REQ-019 rr_ptr SHALL advance to (last granted index + 1) mod NUM_FU when any grant occurs; unchanged when none.
REQ-020 When requesters <= CDB_WIDTH, all SHALL be granted the same cycle.
REQ-021 fu_ready_is bit i SHALL be 1 when state IDLE, or WAIT_CDB with cdb_grant[i]=1 this cycle (back-to-back issue, zero bubble); combinational from state and grant.
REQ-022 Grant and issue to the same FU in one cycle SHALL land in BUSY next cycle (issue wins over IDLE).
REQ-023 squash=1 SHALL force every FU to IDLE next cycle, clear counters, suppress all cdb_grant that cycle, and hold rr_ptr; fu_issue_valid that cycle SHALL be ignored.
REQ-024 cdb_grant SHALL never assert for a FU not in WAIT_CDB.

Reset
REQ-025 On rst=0, asynchronously: all FSMs IDLE, counters 0, rr_ptr 0.
REQ-026 During and after reset until first issue: fu_ready_is all ones, cdb_grant 0, cdb_req 0.
REQ-027 Reset asserted mid-operation SHALL drop all in-flight work with no grants emitted after the assertion edge.

Structure
REQ-028 FU_FSM_STATE enum, CDB_WIDTH, and MULT_LAT default SHALL live in the shared sys_defs package; FU_STATE_PACKET and FU_SELECT reused unchanged.
REQ-029 Round-robin multi-grant selector SHALL be one sub-module, rr_multi_grant (inputs req, ptr; outputs grant, next_ptr), purely combinational.
REQ-030 Per-FU FSM SHALL be a generate loop in the top module; no further sub-modules.

Verification
REQ-031 Reset release, no stimulus -> fu_ready_is all ones, cdb_grant 0 for 10 cycles.
REQ-032 Issue ALU_1 at cycle 0 -> ALU_1 ready=0 cycle 1, cdb_grant[ALU_1]=1 cycle 2, ready=1 cycle 2; reissue at cycle 2 accepted.
REQ-033 Issue MULT_1 with MULT_LAT=4 at cycle 0 -> cdb_grant[MULT_1] first at cycle 5, never earlier.
REQ-034 Issue all 8 FUs, ls_done=2'b11 held -> 8 requesters over cycles: grants 3,3,2 across three consecutive cycles, each FU granted exactly once, rr_ptr wraps 0.
REQ-035 Five FUs in WAIT_CDB, squash=1 -> cdb_grant 0 that cycle, all IDLE and fu_ready_is all ones next cycle.
REQ-036 rst=0 asserted between clock edges while MULT_2 BUSY -> outputs reset immediately, no grant to MULT_2 afterwards.
